// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

    // Widest carry vector the lookahead helper can expand (groups or bits per group).
    localparam int MAXN = 32;

    // Number of lookahead groups for a given operand width and group size.
    function automatic int cla_ng(input int w, input int blk);
        return w / blk;
    endfunction

    // Full lookahead expansion: c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]cin.
    // Each carry is built as an independent sum of products, not chained from
    // the previous carry. Only the low n+1 carries are meaningful.
    function automatic logic [MAXN:0] cla_carries(input logic [MAXN-1:0] g,
                                                  input logic [MAXN-1:0] p,
                                                  input logic            cin,
                                                  input int              n);
        logic [MAXN:0] c;
        logic          term_p;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < MAXN; k++) begin
            if (k < n) begin
                c[k+1] = g[k];
                term_p = p[k];
                for (int j = k - 1; j >= 0; j--) begin
                    c[k+1] = c[k+1] | (term_p & g[j]);
                    term_p = term_p & p[j];
                end
                c[k+1] = c[k+1] | (term_p & cin);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_group.sv
// One BLK-bit lookahead group: group generate/propagate and the sum bits
// given the group's carry-in.
module cla_group
    import cla_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] i_p,
    input  logic [BLK-1:0] i_g,
    input  logic           i_cin,
    output logic [BLK-1:0] o_sum,
    output logic           o_gg,
    output logic           o_gp
);

    logic [BLK-1:0]        w_c;
    logic                  w_unused_co;
    logic [MAXN-BLK-1:0]   w_unused_hi;
    logic [MAXN-BLK-1:0]   w_unused_hi0;
    logic [BLK-1:0]        w_unused_lo0;

    // Intra-group carries from the supplied group carry-in.
    always_comb begin
        {w_unused_hi, w_unused_co, w_c} = cla_carries(MAXN'(i_g), MAXN'(i_p), i_cin, BLK);
    end

    // Group generate is the group carry-out with a zero carry-in.
    always_comb begin
        {w_unused_hi0, o_gg, w_unused_lo0} = cla_carries(MAXN'(i_g), MAXN'(i_p), 1'b0, BLK);
    end

    assign o_sum = i_p ^ w_c;
    assign o_gp  = &i_p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Stage 1 registers p/g and group GG/GP; stage 2 resolves group carries and sums.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int W   = 16,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);

    localparam int NG = cla_ng(W, BLK);

    if ((W % BLK) != 0 || W < BLK || NG >= MAXN || BLK >= MAXN) begin : g_bad_params
        $error("cla_adder_pipe: W must be a non-zero multiple of BLK within lookahead limits");
    end

    logic [W-1:0]        w_bsel;
    logic                w_c0;
    logic [W-1:0]        w_p;
    logic [W-1:0]        w_g;
    logic [NG-1:0]       w_gg;
    logic [NG-1:0]       w_gp;
    logic                w_s1_adv;
    logic                w_s2_adv;
    logic [NG:0]         w_gc;
    logic [MAXN-NG-1:0]  w_unused_ghi;
    logic [W-1:0]        w_sum;
    logic                w_ovf;
    logic [W-1:0]        w_unused_s1_sum;
    logic [NG-1:0]       w_unused_s2_gg;
    logic [NG-1:0]       w_unused_s2_gp;

    logic                r_s1_valid;
    logic [W-1:0]        r_p;
    logic [W-1:0]        r_g;
    logic [NG-1:0]       r_gg;
    logic [NG-1:0]       r_gp;
    logic                r_c0;
    logic                r_a_msb;
    logic                r_b_msb;

    // Subtraction is A + ~B + ~borrow.
    assign w_bsel = in_sub ? ~in_b : in_b;
    assign w_c0   = in_sub ? ~in_cin : in_cin;
    assign w_p    = in_a ^ w_bsel;
    assign w_g    = in_a & w_bsel;

    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    for (genvar j = 0; j < NG; j++) begin : g_s1
        cla_group #(.BLK(BLK)) u_grp (
            .i_p   (w_p[j*BLK +: BLK]),
            .i_g   (w_g[j*BLK +: BLK]),
            .i_cin (1'b0),
            .o_sum (w_unused_s1_sum[j*BLK +: BLK]),
            .o_gg  (w_gg[j]),
            .o_gp  (w_gp[j])
        );
    end

    // Stage 1: capture propagate/generate terms when an operand beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_gg       <= '0;
            r_gp       <= '0;
            r_c0       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_p     <= w_p;
                r_g     <= w_g;
                r_gg    <= w_gg;
                r_gp    <= w_gp;
                r_c0    <= w_c0;
                r_a_msb <= in_a[W-1];
                r_b_msb <= w_bsel[W-1];
            end
        end
    end

    // Group-level carries, each expanded directly from c0 and the GG/GP terms.
    always_comb begin
        {w_unused_ghi, w_gc} = cla_carries(MAXN'(r_gg), MAXN'(r_gp), r_c0, NG);
    end

    for (genvar j = 0; j < NG; j++) begin : g_s2
        cla_group #(.BLK(BLK)) u_grp (
            .i_p   (r_p[j*BLK +: BLK]),
            .i_g   (r_g[j*BLK +: BLK]),
            .i_cin (w_gc[j]),
            .o_sum (w_sum[j*BLK +: BLK]),
            .o_gg  (w_unused_s2_gg[j]),
            .o_gp  (w_unused_s2_gp[j])
        );
    end

    assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[W-1] != r_a_msb);

    // Stage 2: result register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_sum  <= w_sum;
                out_cout <= w_gc[NG];
                out_ovf  <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe at W=16/BLK=4 and W=32/BLK=8.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, out_sum;
    logic        out_valid, out_ready = 1'b1, out_cout, out_ovf;

    // 32-bit instance
    logic        rst_w_n = 1'b0;
    logic        in_valid_w = 1'b0, in_ready_w, in_cin_w = 1'b0, in_sub_w = 1'b0;
    logic [31:0] in_a_w = '0, in_b_w = '0, out_sum_w;
    logic        out_valid_w, out_ready_w = 1'b1, out_cout_w, out_ovf_w;

    cla_adder_pipe #(.W(16), .BLK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    cla_adder_pipe #(.W(32), .BLK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_w_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_a(in_a_w), .in_b(in_b_w), .in_cin(in_cin_w), .in_sub(in_sub_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_sum(out_sum_w),
        .out_cout(out_cout_w), .out_ovf(out_ovf_w)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: {ovf, cout, sum[31:0]}
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint mask, half, ua, ub, sa, sb, r, s;
        logic   co, ov;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
        if (!sub) begin
            r  = ua + ub + longint'(cin);
            co = ((r >> w) != 0);
            s  = sa + sb + longint'(cin);
        end else begin
            r  = ua - ub - longint'(cin);
            co = (r >= 0);
            s  = sa - sb - longint'(cin);
        end
        ov = (s >= half) || (s < -half);
        return {ov, co, 32'(r & mask)};
    endfunction

    logic [33:0] q16[$];
    logic [33:0] q32[$];
    int out_cnt16 = 0, out_cnt32 = 0;

    // Scoreboards: pop on output transfer, push on input accept (sampled mid-cycle).
    always @(negedge clk) begin : b_mon16
        logic [33:0] e;
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt16++;
                if (q16.size() == 0) chk("sb16_extra_output", 64'(out_sum), 64'hx);
                else begin
                    e = q16.pop_front();
                    chk("sb16_result", {30'h0, out_ovf, out_cout, 16'h0, out_sum}, 64'(e));
                end
            end
            if (in_valid && in_ready)
                q16.push_back(model(16, 32'(in_a), 32'(in_b), in_cin, in_sub));
        end
    end

    always @(negedge clk) begin : b_mon32
        logic [33:0] e;
        if (!rst_w_n) begin
            q32.delete();
        end else begin
            if (out_valid_w && out_ready_w) begin
                out_cnt32++;
                if (q32.size() == 0) chk("sb32_extra_output", 64'(out_sum_w), 64'hx);
                else begin
                    e = q32.pop_front();
                    chk("sb32_result", {30'h0, out_ovf_w, out_cout_w, out_sum_w}, 64'(e));
                end
            end
            if (in_valid_w && in_ready_w)
                q32.push_back(model(32, in_a_w, in_b_w, in_cin_w, in_sub_w));
        end
    end

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        @(negedge clk);
        while (!in_ready && n < 100) begin n++; @(negedge clk); end
        if (!in_ready) chk("drive16_accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        in_valid_w = 1'b1; in_a_w = a; in_b_w = b; in_cin_w = cin; in_sub_w = sub;
        @(negedge clk);
        while (!in_ready_w && n < 100) begin n++; @(negedge clk); end
        if (!in_ready_w) chk("drive32_accept_timeout", 64'(in_ready_w), 64'd1);
        @(posedge clk); #1;
        in_valid_w = 1'b0;
    endtask

    task automatic drain16();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q16.size() != 0 || out_valid) && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain16_pending", 64'(q16.size()), 64'd0);
    endtask

    task automatic drain32();
        int n;
        n = 0;
        out_ready_w = 1'b1;
        while ((q32.size() != 0 || out_valid_w) && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain32_pending", 64'(q32.size()), 64'd0);
    endtask

    // Single beat into an idle pipe: output visible one edge after the accept edge.
    task automatic one_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        out_ready = 1'b1;
        drive16(a, b, cin, sub);
        chk({tag, "_valid_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"},   64'(out_sum),   64'(es));
        chk({tag, "_cout"},  64'(out_cout),  64'(ec));
        chk({tag, "_ovf"},   64'(out_ovf),   64'(eo));
        drain16();
    endtask

    int  o0;
    bit  done;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid_held", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        rst_w_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'h0);
        chk("rst_out_cout",  64'(out_cout),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Directed arithmetic
        one_beat("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_beat("add_grpcin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        one_beat("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_beat("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        one_beat("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        one_beat("sub_neg",    16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_beat("sub_borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Backpressure: 4 beats, consumer stalled for 3 cycles
        o0 = out_cnt16;
        out_ready = 1'b0;
        fork
            begin
                drive16(16'h1000, 16'h0001, 1'b0, 1'b0);
                drive16(16'h2000, 16'h0002, 1'b0, 1'b0);
                drive16(16'h3000, 16'h0003, 1'b0, 1'b1);
                drive16(16'h4000, 16'h0004, 1'b1, 1'b0);
            end
            begin
                @(posedge clk); #2;
                @(posedge clk); #2;
                chk("bp_in_ready_low", 64'(in_ready),  64'd0);
                chk("bp_valid",        64'(out_valid), 64'd1);
                chk("bp_sum",          64'(out_sum),   64'h1001);
                @(posedge clk); #2;
                chk("bp_in_ready_still_low", 64'(in_ready), 64'd0);
                chk("bp_sum_hold",           64'(out_sum),  64'h1001);
                out_ready = 1'b1;
            end
        join
        drain16();
        chk("bp_delivered", 64'(out_cnt16 - o0), 64'd4);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b1;
        drive16(16'h0101, 16'h0202, 1'b0, 1'b0);
        drive16(16'h0303, 16'h0404, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_sum",   64'(out_sum),   64'h0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_in_ready", 64'(in_ready),  64'd1);
        chk("arst_no_ghost", 64'(out_valid), 64'd0);
        one_beat("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Random traffic, W=16
        o0 = out_cnt16;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    drive16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
            end
        join
        drain16();
        chk("rand16_delivered", 64'(out_cnt16 - o0), 64'd10000);

        // Random traffic, W=32 / BLK=8
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    drive32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin @(posedge clk); #1; out_ready_w = ($urandom_range(0, 3) != 0); end
            end
        join
        drain32();
        chk("rand32_delivered", 64'(out_cnt32), 64'd10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
